// File: rtl/axi4l_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4l_master_pkg
// Brief    : Shared AXI4-Lite response codes, FSM encoding and defaults.
// Revision : 1.0 - initial release
// ============================================================================
package axi4l_master_pkg;

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;
    localparam logic [1:0] c_resp_decerr = 2'b11;

    localparam int c_timeout_cyc_default = 1024;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_AW = 3'd1,
        WR_B  = 3'd2,
        RD_AR = 3'd3,
        RD_R  = 3'd4,
        RESP  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/axi4l_master.sv
`default_nettype none
// ============================================================================
// Module   : axi4l_master
// Brief    : Single-outstanding request/response port to AXI4-Lite master.
// Revision : 1.0 - initial release
// ============================================================================
module axi4l_master
    import axi4l_master_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = c_timeout_cyc_default
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int   CNT_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int   c_tmo_last = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic c_tmo_en   = (TIMEOUT_CYC > 0);

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wstrb;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_err;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_busy;
    logic                  w_tmo_hit;
    logic                  w_abort;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_b_hs;
    logic                  w_r_hs;

    assign m_axi_awaddr = r_addr;
    assign m_axi_araddr = r_addr;
    assign m_axi_wdata  = r_wdata;
    assign m_axi_wstrb  = r_wstrb;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign rsp_rdata    = r_rdata;
    assign rsp_err      = r_err;

    // Handshakes derived from state rather than the valid outputs to keep the
    // combinational next-state logic free of feedback.
    assign w_aw_hs = (r_state == WR_AW) && !r_aw_done && m_axi_awready;
    assign w_w_hs  = (r_state == WR_AW) && !r_w_done  && m_axi_wready;
    assign w_b_hs  = (r_state == WR_B)  && m_axi_bvalid;
    assign w_r_hs  = (r_state == RD_R)  && m_axi_rvalid;

    assign w_busy    = (r_state != IDLE) && (r_state != RESP);
    assign w_tmo_hit = c_tmo_en && w_busy && (r_cnt == CNT_W'(c_tmo_last));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_abort       = 1'b0;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = req_we ? WR_AW : RD_AR;
                end
            end
            WR_AW: begin
                m_axi_awvalid = !r_aw_done;
                m_axi_wvalid  = !r_w_done;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_state_next = WR_B;
                end else if (w_tmo_hit) begin
                    w_state_next = RESP;
                    w_abort      = 1'b1;
                end
            end
            WR_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    w_state_next = RESP;
                end else if (w_tmo_hit) begin
                    w_state_next = RESP;
                    w_abort      = 1'b1;
                end
            end
            RD_AR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    w_state_next = RD_R;
                end else if (w_tmo_hit) begin
                    w_state_next = RESP;
                    w_abort      = 1'b1;
                end
            end
            RD_R: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid || w_tmo_hit) begin
                    w_state_next = RESP;
                    w_abort      = !m_axi_rvalid;
                end
            end
            RESP: begin
                rsp_valid    = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if ((r_state == IDLE) && req_valid) begin
                r_addr    <= req_addr;
                r_wdata   <= req_wdata;
                r_wstrb   <= req_wstrb;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end
            // Response capture: a completing handshake always beats the timeout.
            if (w_b_hs) begin
                r_rdata <= '0;
                r_err   <= (m_axi_bresp != c_resp_okay);
            end else if (w_r_hs) begin
                r_rdata <= m_axi_rdata;
                r_err   <= (m_axi_rresp != c_resp_okay);
            end else if (w_abort) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if (c_tmo_en && w_busy) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4l_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4l_master
// Brief    : Randomized and directed bench with a cycle-window reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4l_master;
    import axi4l_master_pkg::*;

    localparam int TMO  = 16;
    localparam int NEVER = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_rdata;

    axi4l_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid),
        .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
        .m_axi_rready(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic slave_quiet();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            chk("idle_ready", req_ready, 1'b1);
            chk("idle_rsp", rsp_valid, 1'b0);
            chk("idle_hold", rsp_rdata, last_rdata);
            chk("idle_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // d0: AW/AR delay, d1: W delay, d2: B/R delay (cycles after the channel opens).
    // Any delay >= TMO means the slave never answers on that channel.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] ws, input int d0, input int d1, input int d2,
                           input logic [31:0] sdata, input logic [1:0] sresp, input int rst_at);
        int v0_end, v1_end, p1_end, p2_start, p2_end, rsp_cyc;
        logic tmo;
        logic [31:0] exp_rdata;
        logic exp_err;
        v0_end = (d0 < TMO) ? 1 + d0 : TMO;
        v1_end = we ? ((d1 < TMO) ? 1 + d1 : TMO) : 0;
        tmo    = (d0 >= TMO) || (we && d1 >= TMO);
        p1_end = tmo ? TMO : ((v0_end > v1_end) ? v0_end : v1_end);
        if (tmo) begin
            p2_start = 1000;
            p2_end   = 0;
            rsp_cyc  = p1_end + 1;
        end else begin
            p2_start = p1_end + 1;
            p2_end   = (d2 < TMO) ? p2_start + d2 : p2_start + TMO - 1;
            tmo      = (d2 >= TMO);
            rsp_cyc  = p2_end + 1;
        end
        exp_err   = tmo || (sresp != c_resp_okay);
        exp_rdata = (we || tmo) ? 32'h0 : sdata;

        chk("accept_ready", req_ready, 1'b1);
        chk("accept_rsp", rsp_valid, 1'b0);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = $urandom; req_addr = $urandom;
        req_wdata = $urandom; req_wstrb = 4'($urandom);

        for (int cyc = 1; cyc <= rsp_cyc; cyc++) begin
            chk("req_ready_busy", req_ready, 1'b0);
            chk("awvalid", awvalid, we && cyc <= v0_end);
            chk("wvalid", wvalid, we && cyc <= v1_end);
            chk("bready", bready, we && cyc >= p2_start && cyc <= p2_end);
            chk("arvalid", arvalid, !we && cyc <= v0_end);
            chk("rready", rready, !we && cyc >= p2_start && cyc <= p2_end);
            chk("prot", {awprot, arprot}, 6'b0);
            chk("rsp_valid", rsp_valid, cyc == rsp_cyc);
            if (we && cyc <= v0_end) chk("awaddr", awaddr, addr);
            if (we && cyc <= v1_end) chk("wdata", {wstrb, wdata}, {ws, wd});
            if (!we && cyc <= v0_end) chk("araddr", araddr, addr);
            if (cyc == rsp_cyc) begin
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_err", rsp_err, exp_err);
            end
            slave_quiet();
            if (cyc == rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
                chk("rst_rsp", rsp_valid, 1'b0);
                chk("rst_req_ready", req_ready, 1'b1);
                chk("rst_rdata", rsp_rdata, 32'h0);
                last_rdata = 32'h0;
                idle(3);
                return;
            end
            awready = we && cyc == 1 + d0;
            wready  = we && cyc == 1 + d1;
            arready = !we && cyc == 1 + d0;
            bvalid  = we && cyc == p2_start + d2;
            rvalid  = !we && cyc == p2_start + d2;
            bresp   = sresp;
            rresp   = sresp;
            if (!we && cyc == p2_start + d2) rdata = sdata;
            @(posedge clk);
            @(negedge clk);
        end
        slave_quiet();
        last_rdata = exp_rdata;
    endtask

    function automatic int pick_dly();
        return ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 4));
    endfunction

    function automatic logic [1:0] pick_resp();
        int r;
        r = int'($urandom_range(0, 5));
        return (r == 4) ? c_resp_slverr : (r == 5) ? c_resp_decerr : c_resp_okay;
    endfunction

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_wstrb = '0; last_rdata = '0;
        slave_quiet();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        chk("reset_rsp", {rsp_valid, rsp_err}, 2'b0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        chk("reset_ready", req_ready, 1'b1);
        rst = 1'b0;
        idle(1);

        run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 32'h0, c_resp_okay, 0);
        run_txn(1'b0, 32'h0800_0004, 32'h0, 4'h0, 2, 0, 2, 32'h1234_5678, c_resp_okay, 0);
        run_txn(1'b1, 32'h0000_0020, 32'hA5A5_0001, 4'h3, 0, 3, 1, 32'h0, c_resp_okay, 0);
        run_txn(1'b1, 32'h0000_0024, 32'hA5A5_0002, 4'hC, 3, 0, 0, 32'h0, c_resp_decerr, 0);
        run_txn(1'b0, 32'h0000_0030, 32'h0, 4'h0, 1, 0, 0, 32'hCAFE_F00D, c_resp_slverr, 0);
        run_txn(1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 0, 0, 32'h0BAD_0BAD, c_resp_okay, 0);
        idle(2);
        run_txn(1'b0, 32'h0000_0044, 32'h0, 4'h0, NEVER, 0, 0, 32'h0, c_resp_okay, 0);
        run_txn(1'b1, 32'h0000_0048, 32'h1111_2222, 4'hF, 0, 0, NEVER, 32'h0, c_resp_okay, 0);
        run_txn(1'b0, 32'h0000_004C, 32'h0, 4'h0, 0, 0, 1, 32'h5555_AAAA, c_resp_okay, 0);
        run_txn(1'b1, 32'h0000_0050, 32'h3333_4444, 4'hF, 0, 0, NEVER, 32'h0, c_resp_okay, 3);

        for (int i = 0; i < 60; i++) begin
            run_txn(1'($urandom), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom,
                    4'($urandom), pick_dly(), pick_dly(), pick_dly(), $urandom,
                    pick_resp(), 0);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
